// File: rtl/binary_down_timer_if.sv
// Control and status bundle of the loadable binary down-timer.
// The master side issues load/pause/mode; the slave side (the timer) returns count and status.
interface binary_down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output load, load_val, auto_reload, pause,
        input  count, busy, tc, done
    );

    modport slave (
        input  load, load_val, auto_reload, pause,
        output count, busy, tc, done
    );
endinterface

// File: rtl/binary_down_timer.sv
// Loadable binary down-counter with one-shot or auto-reload mode and a
// single-cycle terminal-count pulse on every expiry.
module binary_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    binary_down_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             tc_q, tc_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            tc_q     <= tc_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // A load wins over everything in the current edge, including a pending expiry,
    // so a restart on the expiry edge never emits a stale tc.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        busy_nxt   = busy_q;
        done_nxt   = done_q;

        if (bus.load) begin
            state_nxt  = RUN;
            count_nxt  = bus.load_val;
            reload_nxt = bus.load_val;
            busy_nxt   = 1'b1;
            done_nxt   = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.pause) begin
                        if (count_q != '0) begin
                            count_nxt = count_q - WIDTH'(1);
                        end else begin
                            tc_nxt = 1'b1;
                            if (bus.auto_reload) begin
                                count_nxt = reload_q;
                            end else begin
                                state_nxt = DONE;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    state_nxt = state;
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_binary_down_timer.sv
// Directed bench for binary_down_timer: hand-computed count/status sequences
// for one-shot, auto-reload, pause, restart, N=0 and reset-in-run cases.
module tb_binary_down_timer;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    binary_down_timer_if #(.WIDTH(WIDTH)) bus ();

    binary_down_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
        chk({tag, ".count"}, 32'(bus.count), 32'(c));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".tc"},    32'(bus.tc),    32'(t));
        chk({tag, ".done"},  32'(bus.done),  32'(d));
    endtask

    task automatic do_load(input int n, input logic ar);
        bus.load        = 1'b1;
        bus.load_val    = 4'(n);
        bus.auto_reload = ar;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.load        = 1'b0;
        bus.load_val    = '0;
        bus.auto_reload = 1'b0;
        bus.pause       = 1'b0;

        // 1: reset held 2 cycles, then idle 10 cycles
        step();
        step();
        chk_all("reset", 0, 0, 0, 0);
        reset = 1'b0;
        bus.pause       = 1'b1;
        bus.auto_reload = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all("idle", 0, 0, 0, 0);
        end
        bus.pause = 1'b0;

        // 2: one-shot N=5; load_val changes after load must not matter
        do_load(5, 1'b0);
        bus.load_val = 4'd9;
        chk_all("os_load", 5, 1, 0, 0);
        for (int k = 4; k >= 0; k--) begin
            step();
            chk_all("os_run", k, 1, 0, 0);
        end
        step();
        chk_all("os_expire", 0, 0, 1, 1);
        step();
        chk_all("os_done", 0, 0, 0, 1);
        bus.pause = 1'b1;
        step();
        chk_all("os_done_hold", 0, 0, 0, 1);
        bus.pause = 1'b0;

        // 3: auto-reload N=3 for 20 cycles
        do_load(3, 1'b1);
        chk_all("ar_load", 3, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_all("ar_run", 3 - (k % 4), 1, ((k % 4) == 0) ? 1 : 0, 0);
        end

        // 4: N=4 one-shot, pause 3 cycles at count=2
        do_load(4, 1'b0);
        chk_all("pz_load", 4, 1, 0, 0);
        step();
        chk_all("pz_3", 3, 1, 0, 0);
        step();
        chk_all("pz_2", 2, 1, 0, 0);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("pz_hold", 2, 1, 0, 0);
        end
        bus.pause = 1'b0;
        step();
        chk_all("pz_1", 1, 1, 0, 0);
        step();
        chk_all("pz_0", 0, 1, 0, 0);
        step();
        chk_all("pz_expire", 0, 0, 1, 1);

        // 5: restart N=9 with N=2 at count=6, then N=0 auto-reload
        do_load(9, 1'b0);
        step();
        step();
        step();
        chk_all("rl_6", 6, 1, 0, 0);
        do_load(2, 1'b0);
        chk_all("rl_2", 2, 1, 0, 0);
        step();
        chk_all("rl_1", 1, 1, 0, 0);
        step();
        chk_all("rl_0", 0, 1, 0, 0);
        step();
        chk_all("rl_expire", 0, 0, 1, 1);

        do_load(0, 1'b1);
        chk_all("n0_load", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("n0_steady", 0, 1, 1, 0);
        end
        bus.auto_reload = 1'b0;
        step();
        chk_all("n0_stop", 0, 0, 1, 1);
        step();
        chk_all("n0_after", 0, 0, 0, 1);

        // 6: reset at count=3 mid-run, then load on the expiry edge
        do_load(5, 1'b0);
        step();
        step();
        chk_all("rs_3", 3, 1, 0, 0);
        reset = 1'b1;
        step();
        chk_all("rs_reset", 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk_all("rs_quiet", 0, 0, 0, 0);

        do_load(2, 1'b0);
        step();
        step();
        chk_all("le_0", 0, 1, 0, 0);
        do_load(7, 1'b0);
        chk_all("le_load", 7, 1, 0, 0);
        step();
        chk_all("le_6", 6, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
